// File: rtl/stripes_pkg.sv
// Purpose: shared types and defaults for the stripes dispatch/serial-compute blocks.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package stripes_pkg;

    localparam int DEF_PARALLEL_WINDOWS = 16;
    localparam int DEF_SEL_BITS         = 4;
    localparam int DEF_AW               = 16;
    localparam int PREC_W               = 5;   // precision field width (values 1..16)
    localparam int BIT_IDX_W            = 4;   // bit position index width
    localparam int MAX_PREC             = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // MSB bit position for a precision; 0 (and anything out of range) means full 16 bits.
    function automatic logic [BIT_IDX_W-1:0] prec_msb(input logic [PREC_W-1:0] prec);
        if (prec == '0 || prec > PREC_W'(MAX_PREC)) begin
            return BIT_IDX_W'(MAX_PREC - 1);
        end
        return BIT_IDX_W'(prec - PREC_W'(1));
    endfunction

endpackage

// File: rtl/bit_stream_counter.sv
// Purpose: MSB-first bit position down-counter with stall; shared with the serial inner-product units.
// Latency: o_count valid the cycle after i_load; one position per unstalled cycle.
// Backpressure: i_stall freezes the count; o_valid is low while stalled.
// Ports: i_load/i_load_val start a stream at the given MSB; o_active while streaming;
//        o_valid = streaming and not stalled; o_last = o_valid at bit 0 (stream completes).
module bit_stream_counter
    import stripes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [BIT_IDX_W-1:0] i_load_val,
    input  logic                 i_stall,
    output logic [BIT_IDX_W-1:0] o_count,
    output logic                 o_active,
    output logic                 o_valid,
    output logic                 o_last
);

    logic [BIT_IDX_W-1:0] cnt_q, cnt_d;
    logic                 act_q, act_d;

    always_comb begin
        cnt_d = cnt_q;
        act_d = act_q;
        if (i_load) begin
            cnt_d = i_load_val;
            act_d = 1'b1;
        end else if (act_q && !i_stall) begin
            // Count stays at 0 after the last bit so the index output rests at 0.
            if (cnt_q == '0) begin
                act_d = 1'b0;
            end else begin
                cnt_d = cnt_q - BIT_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            act_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end

    assign o_count  = cnt_q;
    assign o_active = act_q;
    assign o_valid  = act_q && !i_stall;
    assign o_last   = act_q && !i_stall && (cnt_q == '0);

endmodule

// File: rtl/dispatch_sequencer.sv
// Purpose: sequences row loads into the double-buffered dispatcher and MSB-first bit streaming out of it.
// Latency: first request the cycle after start; per group max(2*PARALLEL_WINDOWS, P)+1 cycles at 1-cycle memory.
// Backpressure: i_stall freezes the bit stream only; loading continues, the swap waits for the stream.
// Ports: i_start/i_base_addr/i_num_groups/i_precision job setup; o_mem_req/o_mem_addr/i_mem_valid row reads;
//        o_enable/o_sel/o_read_buf dispatcher control; o_stream_valid/o_bit_idx stream; o_busy/o_done status.
module dispatch_sequencer
    import stripes_pkg::*;
#(
    parameter int PARALLEL_WINDOWS = DEF_PARALLEL_WINDOWS,
    parameter int SEL_BITS         = DEF_SEL_BITS,
    parameter int AW               = DEF_AW
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [AW-1:0]                    i_base_addr,
    input  logic [AW-1:0]                    i_num_groups,
    input  logic [PREC_W-1:0]                i_precision,
    output logic                             o_mem_req,
    output logic [AW-1:0]                    o_mem_addr,
    input  logic                             i_mem_valid,
    output logic [PARALLEL_WINDOWS-1:0]      o_enable,
    output logic [SEL_BITS*PARALLEL_WINDOWS-1:0] o_sel,
    output logic                             o_read_buf,
    input  logic                             i_stall,
    output logic                             o_stream_valid,
    output logic [BIT_IDX_W-1:0]             o_bit_idx,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int WIN_W = (PARALLEL_WINDOWS > 1) ? $clog2(PARALLEL_WINDOWS) : 1;

    seq_state_t           state_q;
    logic [AW-1:0]        base_q;
    logic [AW-1:0]        num_grp_q;
    logic [AW-1:0]        grp_q;        // group currently being loaded
    logic [BIT_IDX_W-1:0] msb_q;
    logic [WIN_W-1:0]     win_q;        // window currently being loaded
    logic                 req_q;
    logic                 outst_q;      // one read in flight
    logic                 load_done_q;
    logic                 read_buf_q;

    logic                 resp_ok;
    logic                 swap;
    logic [AW-1:0]        grp_next;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic                 cnt_active;
    logic                 cnt_valid;
    logic                 cnt_last;

    // Responses only count while a request is in flight; reset clears the in-flight
    // flag, so a response to a pre-reset request is dropped.
    assign resp_ok  = outst_q && i_mem_valid;
    // In FILL the counter is idle, so the swap waits on the load alone.
    assign swap     = (state_q == ST_FILL || state_q == ST_RUN) && load_done_q && !cnt_active;
    assign grp_next = grp_q + AW'(1);

    bit_stream_counter u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (swap),
        .i_load_val (msb_q),
        .i_stall    (i_stall),
        .o_count    (bit_idx),
        .o_active   (cnt_active),
        .o_valid    (cnt_valid),
        .o_last     (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            num_grp_q   <= '0;
            grp_q       <= '0;
            msb_q       <= '0;
            win_q       <= '0;
            req_q       <= 1'b0;
            outst_q     <= 1'b0;
            load_done_q <= 1'b0;
            read_buf_q  <= 1'b1;
        end else begin
            req_q <= 1'b0;
            if (req_q) begin
                outst_q <= 1'b1;
            end
            if (resp_ok) begin
                outst_q <= 1'b0;
                if (win_q == WIN_W'(PARALLEL_WINDOWS - 1)) begin
                    win_q       <= '0;
                    load_done_q <= 1'b1;
                end else begin
                    win_q <= win_q + WIN_W'(1);
                    req_q <= 1'b1;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        base_q      <= i_base_addr;
                        num_grp_q   <= i_num_groups;
                        msb_q       <= prec_msb(i_precision);
                        grp_q       <= '0;
                        win_q       <= '0;
                        load_done_q <= 1'b0;
                        if (i_num_groups == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_FILL;
                            req_q   <= 1'b1;
                        end
                    end
                end
                ST_FILL, ST_RUN: begin
                    // The swap hands the just-loaded buffer to the stream and
                    // starts loading the next group into the other one.
                    if (swap) begin
                        read_buf_q  <= ~read_buf_q;
                        grp_q       <= grp_next;
                        load_done_q <= 1'b0;
                        if (grp_next < num_grp_q) begin
                            state_q <= ST_RUN;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt_last) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req      = req_q;
    assign o_mem_addr     = base_q + grp_q * AW'(PARALLEL_WINDOWS) + AW'(win_q);
    assign o_enable       = resp_ok ? (PARALLEL_WINDOWS'(1) << win_q) : '0;
    assign o_read_buf     = read_buf_q;
    assign o_stream_valid = cnt_valid;
    assign o_bit_idx      = bit_idx;
    assign o_busy         = (state_q == ST_FILL) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_done         = (state_q == ST_DONE);

    // FILL is load-only, so fields carry their window index; once streaming
    // starts the dispatcher needs every field pointing at the current bit.
    always_comb begin
        o_sel = '0;
        for (int w = 0; w < PARALLEL_WINDOWS; w++) begin
            if (state_q == ST_FILL) begin
                o_sel[w*SEL_BITS +: SEL_BITS] = SEL_BITS'(w);
            end else if (state_q == ST_RUN || state_q == ST_DRAIN) begin
                o_sel[w*SEL_BITS +: SEL_BITS] = SEL_BITS'(bit_idx);
            end
        end
    end

endmodule

// File: tb/tb_dispatch_sequencer.sv
module tb_dispatch_sequencer;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [15:0] i_base_addr;
    logic [15:0] i_num_groups;
    logic [4:0]  i_precision;
    logic        o_mem_req;
    logic [15:0] o_mem_addr;
    logic        i_mem_valid;
    logic [15:0] o_enable;
    logic [63:0] o_sel;
    logic        o_read_buf;
    logic        i_stall;
    logic        o_stream_valid;
    logic [3:0]  o_bit_idx;
    logic        o_busy;
    logic        o_done;

    int total;
    int bad;

    logic [15:0] exp_addr_q[$];
    logic [3:0]  exp_bit_q[$];

    dispatch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_num_groups   (i_num_groups),
        .i_precision    (i_precision),
        .o_mem_req      (o_mem_req),
        .o_mem_addr     (o_mem_addr),
        .i_mem_valid    (i_mem_valid),
        .o_enable       (o_enable),
        .o_sel          (o_sel),
        .o_read_buf     (o_read_buf),
        .i_stall        (i_stall),
        .o_stream_valid (o_stream_valid),
        .o_bit_idx      (o_bit_idx),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one job with a latency-`lat` memory model; checks addresses, enables,
    // bit order, select fields and swap cycles against queues filled up front.
    task automatic run_job(input logic [15:0] base, input logic [15:0] ngrp, input logic [4:0] prec,
                           input int lat, input bit do_stall, input bit noisy,
                           output int n_req, output int n_valid, output int n_swap,
                           output int done_cyc, output int last_vld, output int n_ovl,
                           output int n_stall);
        int p; int cd; bit pend; int resp_idx; int stall_left; bit armed;
        bit prev_rb; bit prev_vld; bit prev_req; bit got_done;
        logic [63:0] sel_fill; logic [15:0] a; logic [15:0] en_exp; logic [3:0] b_exp;
        p = (prec == 5'd0 || prec > 5'd16) ? 16 : int'(prec);
        n_req = 0; n_valid = 0; n_swap = 0; done_cyc = -1; last_vld = -1; n_ovl = 0; n_stall = 0;
        cd = 0; pend = 0; resp_idx = 0; stall_left = 0; armed = do_stall; got_done = 0;
        for (int w = 0; w < 16; w++) sel_fill[w*4 +: 4] = 4'(w);
        exp_addr_q.delete();
        exp_bit_q.delete();
        for (int g = 0; g < int'(ngrp); g++) begin
            for (int w = 0; w < 16; w++) begin
                a = base + 16'(g*16 + w);
                exp_addr_q.push_back(a);
            end
            for (int b = p - 1; b >= 0; b--) exp_bit_q.push_back(4'(b));
        end
        i_base_addr = base; i_num_groups = ngrp; i_precision = prec; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        prev_rb = o_read_buf; prev_vld = 1'b0; prev_req = 1'b0;
        for (int cyc = 1; cyc <= 4000 && !got_done; cyc++) begin
            i_mem_valid = 1'b0;
            if (pend) begin
                cd--;
                if (cd == 0) begin i_mem_valid = 1'b1; pend = 1'b0; end
            end
            i_stall = (stall_left > 0);
            i_start = noisy && o_busy;
            if (noisy) begin
                i_base_addr  = 16'($urandom);
                i_num_groups = 16'($urandom_range(1, 7));
                i_precision  = 5'($urandom_range(1, 16));
            end
            #1;
            if (armed && o_stream_valid && o_bit_idx == 4'd4) begin
                i_stall = 1'b1; stall_left = 5; armed = 1'b0;
                #1;
            end
            if (o_read_buf !== prev_rb) begin
                n_swap++;
                total++;
                if (prev_vld || prev_req) begin
                    bad++;
                    $display("FAIL swap_cycle: cyc=%0d valid=%0b req=%0b required 0/0", cyc, prev_vld, prev_req);
                end
            end
            if (i_mem_valid) begin
                en_exp = 16'(1) << (resp_idx % 16);
                total++;
                if (o_enable !== en_exp) begin
                    bad++;
                    $display("FAIL enable: cyc=%0d got %h required %h", cyc, o_enable, en_exp);
                end
                resp_idx++;
            end
            if (o_mem_req) begin
                n_req++;
                total++;
                if (exp_addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_req: cyc=%0d addr %h, required no request", cyc, o_mem_addr);
                end else begin
                    a = exp_addr_q.pop_front();
                    if (o_mem_addr !== a) begin
                        bad++;
                        $display("FAIL mem_addr: cyc=%0d got %h required %h", cyc, o_mem_addr, a);
                    end
                end
                if (n_swap == 0) begin
                    total++;
                    if (o_sel !== sel_fill) begin
                        bad++;
                        $display("FAIL fill_sel: got %h required %h", o_sel, sel_fill);
                    end
                end
                pend = 1'b1; cd = lat;
            end
            if (o_stream_valid) begin
                n_valid++;
                last_vld = cyc;
                if (pend || o_mem_req || i_mem_valid) n_ovl++;
                total++;
                if (exp_bit_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_bit: cyc=%0d bit_idx %0d, required no stream", cyc, o_bit_idx);
                end else begin
                    b_exp = exp_bit_q.pop_front();
                    if (o_bit_idx !== b_exp) begin
                        bad++;
                        $display("FAIL bit_idx: cyc=%0d got %0d required %0d", cyc, o_bit_idx, b_exp);
                    end
                end
                total++;
                if (o_sel !== {16{o_bit_idx}}) begin
                    bad++;
                    $display("FAIL stream_sel: got %h required %h", o_sel, {16{o_bit_idx}});
                end
            end
            if (i_stall) begin
                n_stall++;
                stall_left--;
                total++;
                if (o_stream_valid !== 1'b0 || o_bit_idx !== 4'd4) begin
                    bad++;
                    $display("FAIL stall_hold: valid=%0b bit_idx=%0d required 0 and 4", o_stream_valid, o_bit_idx);
                end
            end
            prev_rb = o_read_buf; prev_vld = o_stream_valid; prev_req = o_mem_req;
            if (o_done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                total++;
                if (o_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL done_busy: busy=%0b required 0", o_busy);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        i_start = 1'b0; i_stall = 1'b0; i_mem_valid = 1'b0;
        total++;
        if (!got_done) begin
            bad++;
            $display("FAIL timeout: no o_done within cycle budget, required done");
        end
        total++;
        if (exp_addr_q.size() != 0 || exp_bit_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: addr=%0d bits=%0d required 0/0", exp_addr_q.size(), exp_bit_q.size());
        end
        @(posedge clk); #1;
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%0b busy=%0b after pulse, required 0/0", o_done, o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_num_groups = '0; i_precision = '0;
        i_mem_valid = 1'b0; i_stall = 1'b0;
        #3;
        total++;
        if (o_read_buf !== 1'b1 || o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
            o_stream_valid !== 1'b0 || o_bit_idx !== 4'd0 || o_sel !== 64'd0 || o_enable !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: rb=%0b req=%0b busy=%0b done=%0b vld=%0b idx=%0d sel=%h en=%h required 1,0,...",
                     o_read_buf, o_mem_req, o_busy, o_done, o_stream_valid, o_bit_idx, o_sel, o_enable);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_group();
        int nr, nv, ns, dc, lv, no, nst;
        total++;
        if (o_read_buf !== 1'b1) begin
            bad++;
            $display("FAIL single_rb_start: got %0b required 1", o_read_buf);
        end
        run_job(16'h0100, 16'd1, 5'd8, 1, 1'b0, 1'b0, nr, nv, ns, dc, lv, no, nst);
        total++; if (nr != 16) begin bad++; $display("FAIL single_reqs: got %0d required 16", nr); end
        total++; if (nv != 8)  begin bad++; $display("FAIL single_valids: got %0d required 8", nv); end
        total++; if (ns != 1)  begin bad++; $display("FAIL single_swaps: got %0d required 1", ns); end
        total++; if (o_read_buf !== 1'b0) begin bad++; $display("FAIL single_rb_end: got %0b required 0", o_read_buf); end
        total++; if (dc != 42) begin bad++; $display("FAIL single_latency: done at %0d required 42", dc); end
        total++; if (dc != lv + 1) begin bad++; $display("FAIL single_done_pos: done %0d last bit %0d required last+1", dc, lv); end
    endtask

    task automatic test_multi_group_overlap();
        int nr, nv, ns, dc, lv, no, nst;
        run_job(16'h2000, 16'd3, 5'd16, 3, 1'b0, 1'b0, nr, nv, ns, dc, lv, no, nst);
        total++; if (nr != 48) begin bad++; $display("FAIL multi_reqs: got %0d required 48", nr); end
        total++; if (nv != 48) begin bad++; $display("FAIL multi_valids: got %0d required 48", nv); end
        total++; if (ns != 3)  begin bad++; $display("FAIL multi_swaps: got %0d required 3", ns); end
        total++; if (no == 0)  begin bad++; $display("FAIL multi_overlap: got %0d overlapped cycles required >0", no); end
        total++; if (dc != lv + 1) begin bad++; $display("FAIL multi_done_pos: done %0d last bit %0d required last+1", dc, lv); end
    endtask

    task automatic test_stall();
        int nr, nv, ns, dc, lv, no, nst;
        run_job(16'h0040, 16'd1, 5'd8, 1, 1'b1, 1'b0, nr, nv, ns, dc, lv, no, nst);
        total++; if (nst != 5) begin bad++; $display("FAIL stall_cycles: got %0d required 5", nst); end
        total++; if (nv != 8)  begin bad++; $display("FAIL stall_valids: got %0d required 8", nv); end
        total++; if (dc != 47) begin bad++; $display("FAIL stall_latency: done at %0d required 47", dc); end
    endtask

    task automatic test_zero_groups();
        int nr, nv, ns, dc, lv, no, nst;
        run_job(16'h1234, 16'd0, 5'd8, 1, 1'b0, 1'b0, nr, nv, ns, dc, lv, no, nst);
        total++; if (nr != 0) begin bad++; $display("FAIL zero_reqs: got %0d required 0", nr); end
        total++; if (dc != 1) begin bad++; $display("FAIL zero_done: done at %0d required 1", dc); end
        total++; if (ns != 0) begin bad++; $display("FAIL zero_swaps: got %0d required 0", ns); end
    endtask

    task automatic test_addr_wrap();
        int nr, nv, ns, dc, lv, no, nst;
        run_job(16'hFFF8, 16'd1, 5'd4, 1, 1'b0, 1'b0, nr, nv, ns, dc, lv, no, nst);
        total++; if (nr != 16) begin bad++; $display("FAIL wrap_reqs: got %0d required 16", nr); end
        total++; if (dc != 38) begin bad++; $display("FAIL wrap_latency: done at %0d required 38", dc); end
    endtask

    // Precision 0 means 16 bits; i_start is held during the job and must be ignored.
    task automatic test_back_to_back();
        int nr, nv, ns, dc, lv, no, nst;
        run_job(16'h0500, 16'd2, 5'd0, 1, 1'b0, 1'b1, nr, nv, ns, dc, lv, no, nst);
        total++; if (nr != 32) begin bad++; $display("FAIL b2b_reqs: got %0d required 32", nr); end
        total++; if (nv != 32) begin bad++; $display("FAIL b2b_valids: got %0d required 32", nv); end
        total++; if (ns != 2)  begin bad++; $display("FAIL b2b_swaps: got %0d required 2", ns); end
        total++; if (dc != 83) begin bad++; $display("FAIL b2b_latency: done at %0d required 83", dc); end
    endtask

    task automatic test_reset_mid_run();
        bit seen; bit pend; int cd;
        seen = 1'b0; pend = 1'b0; cd = 0;
        i_base_addr = 16'h3000; i_num_groups = 16'd3; i_precision = 5'd16; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            i_mem_valid = 1'b0;
            if (pend) begin
                cd--;
                if (cd == 0) begin i_mem_valid = 1'b1; pend = 1'b0; end
            end
            #1;
            if (o_mem_req) begin
                pend = 1'b1; cd = 2;
                if (o_read_buf == 1'b0 && o_busy) seen = 1'b1;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_mid_timeout: no RUN-phase request seen, required one");
        end
        i_mem_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (o_busy !== 1'b0 || o_read_buf !== 1'b1 || o_mem_req !== 1'b0 || o_stream_valid !== 1'b0 ||
            o_bit_idx !== 4'd0 || o_sel !== 64'd0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_state: busy=%0b rb=%0b req=%0b vld=%0b idx=%0d sel=%h done=%0b required 0,1,0,0,0,0,0",
                     o_busy, o_read_buf, o_mem_req, o_stream_valid, o_bit_idx, o_sel, o_done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        i_mem_valid = 1'b1;
        #1;
        total++;
        if (o_enable !== 16'd0) begin
            bad++;
            $display("FAIL late_resp_enable: got %h required 0000", o_enable);
        end
        @(posedge clk); #1;
        i_mem_valid = 1'b0;
        total++;
        if (o_mem_req !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL late_resp_idle: req=%0b busy=%0b required 0/0", o_mem_req, o_busy);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single_group();
        test_multi_group_overlap();
        test_stall();
        test_zero_groups();
        test_addr_wrap();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dispatch_sequencer.md
DISPATCH_SEQUENCER -- requirements
Module: dispatch_sequencer

Interface
REQ-001 SHALL have parameter PARALLEL_WINDOWS, default 16, meaning windows (transposer slots) per buffer.
REQ-002 SHALL have parameter SEL_BITS, default 4, meaning width of one per-window select field.
REQ-003 SHALL have parameter AW, default 16, meaning row address width.
REQ-004 SHALL have ports:
- clk  in  1  clock; one clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- i_start  in  1  pulse, accepted only in IDLE.
- i_base_addr  in  AW  first row address, sampled on i_start.
- i_num_groups  in  AW  row groups to process (0 = none), sampled on i_start.
- i_precision  in  5  bits per value (1..16), sampled on i_start; 0 treated as 16.
- o_mem_req  out  1  one-cycle row read request.
- o_mem_addr  out  AW  row address, valid with o_mem_req.
- i_mem_valid  in  1  row data on the dispatcher memory bus this cycle.
- o_enable  out  PARALLEL_WINDOWS  per-window write enable to the dispatcher.
- o_sel  out  SEL_BITS*PARALLEL_WINDOWS  per-window select.
- o_read_buf  out  1  dispatcher buffer select.
- i_stall  in  1  downstream backpressure.
- o_stream_valid  out  1  dispatcher o_stream is valid this cycle.
- o_bit_idx  out  4  bit position currently streamed.
- o_busy  out  1  not IDLE.
- o_done  out  1  one-cycle completion pulse.

Function
REQ-005 SHALL implement states IDLE, FILL, RUN, DRAIN and DONE.
REQ-006 SHALL make the transitions:
- IDLE->FILL on i_start with i_num_groups!=0.
- IDLE->DONE on i_start with i_num_groups==0.
- FILL->RUN at the first swap when groups remain, else FILL->DRAIN.
- RUN->DRAIN at the swap that loads the last group.
- DRAIN->DONE when the stream completes.
- DONE->IDLE after one cycle.
REQ-007 SHALL write into buffer b0 when o_read_buf=1 and into b1 when o_read_buf=0; o_read_buf SHALL toggle only at a swap.
REQ-008 Load: SHALL issue PARALLEL_WINDOWS reads per group with at most one outstanding; address = base + g*PARALLEL_WINDOWS + w, with wrap modulo 2^AW.
REQ-009 SHALL assert o_mem_req in the cycle after the previous i_mem_valid, or the cycle after entering FILL or after a swap; a response SHALL be accepted at any latency ≥1.
REQ-010 o_enable SHALL equal onehot(w) ANDed with i_mem_valid, combinationally; i_mem_valid with no request outstanding SHALL be ignored (enable 0).
REQ-011 During load, o_sel field w SHALL equal w mod 2^SEL_BITS; during streaming, every field SHALL equal o_bit_idx.
REQ-012 Stream (RUN, DRAIN): o_bit_idx SHALL start at P-1 and decrement, MSB first; o_stream_valid=!i_stall; i_stall SHALL freeze o_bit_idx; the stream completes in the cycle bit 0 is valid.
REQ-013 Swap SHALL occur when the load is complete and the stream is complete (or no stream is active, as in FILL); loading and streaming SHALL overlap in RUN.
REQ-014 In the swap cycle, o_stream_valid=0 and o_mem_req=0; the group counter increments.
REQ-015 o_busy=1 in FILL, RUN and DRAIN; o_done=1 only in DONE.
REQ-016 i_start outside IDLE SHALL be ignored.
REQ-017 Per-group cycles with no stall and one-cycle memory latency SHALL equal max(2*PARALLEL_WINDOWS, P) + 1.

Reset
REQ-018 On rst, in any state including mid-load, SHALL enter IDLE with o_read_buf=1 and all other outputs 0 (o_bit_idx=0, o_sel=0).
REQ-019 A response arriving after reset release for a pre-reset request SHALL be ignored.

Structure
REQ-020 SHALL place the state encoding, default parameters and precision width in shared package stripes_pkg.
REQ-021 SHALL contain one sub-module, bit_stream_counter (the down-counter with stall and a done flag), reused by the serial inner-product units.

Verification
REQ-022 SHALL cover these directed scenarios:
- num_groups=1, P=8, latency 1: 16 requests at addresses base..base+15; read_buf toggles 1->0; 8 valid cycles with bit_idx 7..0; done pulse.
- num_groups=3, P=16, latency 3: loading overlaps streaming; 3 swaps; 48 requests; done after the last bit_idx=0.
- i_stall high for 5 cycles mid-stream at bit_idx=4: bit_idx holds at 4, valid=0 throughout, then resumes 4..0.
- i_num_groups=0: done one cycle after start, no o_mem_req.
- rst asserted mid-RUN with a request outstanding: IDLE immediately, read_buf=1, and a late i_mem_valid produces enable=0.
- base=0xFFF8, num_groups=1: addresses wrap 0xFFF8..0x0007.
